// File: rtl/wbp2classic_buffered.sv
// Pipelined Wishbone slave to classic Wishbone master bridge with a request FIFO.
// Requests are queued, then replayed one at a time downstream with a one-cycle gap between them.
module wbp2classic_buffered #(
  parameter int AW      = 12,
  parameter int DW      = 32,
  parameter int LGFIFO  = 2,
  parameter int TIMEOUT = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_scyc,
  input  logic              i_sstb,
  input  logic              i_swe,
  input  logic [AW-1:0]     i_saddr,
  input  logic [DW-1:0]     i_sdata,
  input  logic [DW/8-1:0]   i_ssel,
  output logic              o_sstall,
  output logic              o_sack,
  output logic              o_serr,
  output logic [DW-1:0]     o_sdata,
  output logic              o_mcyc,
  output logic              o_mstb,
  output logic              o_mwe,
  output logic [AW-1:0]     o_maddr,
  output logic [DW-1:0]     o_mdata,
  output logic [DW/8-1:0]   o_msel,
  input  logic              i_mack,
  input  logic              i_merr,
  input  logic [DW-1:0]     i_mdata,
  output logic [2:0]        o_mcti,
  output logic [1:0]        o_mbte
);

  localparam int SW    = DW / 8;
  localparam int EW    = 1 + AW + DW + SW;
  localparam int DEPTH = 1 << LGFIFO;
  localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [TW-1:0]     TMO_VAL = TW'(TIMEOUT);
  localparam logic [TW-1:0]     TMR_ONE = TW'(1'b1);
  localparam logic [LGFIFO:0]   CNT_ONE = (LGFIFO + 1)'(1'b1);
  localparam logic [LGFIFO-1:0] PTR_ONE = LGFIFO'(1'b1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACTIVE   = 2'd1,
    S_GAP      = 2'd2,
    S_ERRDRAIN = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [EW-1:0]     r_mem [0:DEPTH-1];
  logic [LGFIFO-1:0] r_wptr, r_rptr;
  logic [LGFIFO:0]   r_count;
  logic [TW-1:0]     r_timer, w_timer_nxt;
  logic              r_mcyc, r_mstb, r_sack, r_serr;
  logic              w_mcyc_nxt, w_mstb_nxt, w_sack_nxt, w_serr_nxt;
  logic              r_mwe;
  logic [AW-1:0]     r_maddr;
  logic [DW-1:0]     r_mdata, r_sdata;
  logic [SW-1:0]     r_msel;
  logic              w_push, w_pop, w_flush, w_launch;
  logic              w_full, w_empty, w_timeout;
  logic [EW-1:0]     w_head;

  // The count MSB is set only when all 2^LGFIFO slots are occupied.
  assign w_full    = r_count[LGFIFO];
  assign w_empty   = (r_count == {(LGFIFO + 1){1'b0}});
  assign o_sstall  = w_full || (r_state == S_ERRDRAIN);
  assign w_push    = i_scyc && i_sstb && !o_sstall;
  assign w_head    = r_mem[r_rptr];
  assign w_timeout = (TIMEOUT > 0) && (r_timer == TMO_VAL);

  // Next-state and next-output decode; a dropped i_scyc overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_mcyc_nxt  = r_mcyc;
    w_mstb_nxt  = r_mstb;
    w_sack_nxt  = 1'b0;
    w_serr_nxt  = 1'b0;
    w_timer_nxt = r_timer;
    w_pop       = 1'b0;
    w_flush     = 1'b0;
    w_launch    = 1'b0;
    if (!i_scyc) begin
      w_state_nxt = S_IDLE;
      w_mcyc_nxt  = 1'b0;
      w_mstb_nxt  = 1'b0;
      w_flush     = 1'b1;
    end else begin
      case (r_state)
        S_IDLE, S_GAP: begin
          if (!w_empty) begin
            w_launch    = 1'b1;
            w_state_nxt = S_ACTIVE;
            w_mcyc_nxt  = 1'b1;
            w_mstb_nxt  = 1'b1;
            w_timer_nxt = {TW{1'b0}};
          end else begin
            w_state_nxt = S_IDLE;
            w_mcyc_nxt  = 1'b0;
            w_mstb_nxt  = 1'b0;
          end
        end
        S_ACTIVE: begin
          if (i_merr || w_timeout) begin
            w_state_nxt = S_ERRDRAIN;
            w_serr_nxt  = 1'b1;
            w_flush     = 1'b1;
            w_mcyc_nxt  = 1'b0;
            w_mstb_nxt  = 1'b0;
          end else if (i_mack) begin
            w_state_nxt = S_GAP;
            w_pop       = 1'b1;
            w_sack_nxt  = 1'b1;
            w_mstb_nxt  = 1'b0;
          end else begin
            w_timer_nxt = r_timer + TMR_ONE;
          end
        end
        S_ERRDRAIN: begin
          w_mcyc_nxt = 1'b0;
          w_mstb_nxt = 1'b0;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_mcyc_nxt  = 1'b0;
          w_mstb_nxt  = 1'b0;
          w_flush     = 1'b1;
        end
      endcase
    end
  end

  // Control state and handshake outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_mcyc  <= 1'b0;
      r_mstb  <= 1'b0;
      r_sack  <= 1'b0;
      r_serr  <= 1'b0;
      r_timer <= {TW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_mcyc  <= w_mcyc_nxt;
      r_mstb  <= w_mstb_nxt;
      r_sack  <= w_sack_nxt;
      r_serr  <= w_serr_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // FIFO pointers; a flush discards anything pushed in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset || w_flush) begin
      r_wptr  <= {LGFIFO{1'b0}};
      r_rptr  <= {LGFIFO{1'b0}};
      r_count <= {(LGFIFO + 1){1'b0}};
    end else begin
      if (w_push)
        r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)
        r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge i_clk) begin
    if (w_push)
      r_mem[r_wptr] <= {i_swe, i_saddr, i_sdata, i_ssel};
  end

  // Datapath registers: the head is latched on launch, read data only on a forwarded ack.
  always_ff @(posedge i_clk) begin
    if (w_launch)
      {r_mwe, r_maddr, r_mdata, r_msel} <= w_head;
    if (w_pop)
      r_sdata <= i_mdata;
  end

  assign o_mcyc  = r_mcyc;
  assign o_mstb  = r_mstb;
  assign o_sack  = r_sack;
  assign o_serr  = r_serr;
  assign o_sdata = r_sdata;
  assign o_mwe   = r_mwe;
  assign o_maddr = r_maddr;
  assign o_mdata = r_mdata;
  assign o_msel  = r_msel;
  assign o_mcti  = 3'b000;
  assign o_mbte  = 2'b00;

endmodule

// File: tb/tb_wbp2classic_buffered.sv
// Directed bench for wbp2classic_buffered: a scripted classic slave answers downstream
// cycles and logs what it sees; the main sequence checks timing against hand-derived cycles.
module tb_wbp2classic_buffered;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_scyc, i_sstb, i_swe;
  logic [11:0] i_saddr;
  logic [31:0] i_sdata;
  logic [3:0]  i_ssel;
  logic        o_sstall, o_sack, o_serr;
  logic [31:0] o_sdata;
  logic        o_mcyc, o_mstb, o_mwe;
  logic [11:0] o_maddr;
  logic [31:0] o_mdata;
  logic [3:0]  o_msel;
  logic        i_mack, i_merr;
  logic [31:0] i_mdata;
  logic [2:0]  o_mcti;
  logic [1:0]  o_mbte;

  always #5 i_clk = ~i_clk;

  wbp2classic_buffered #(.AW(12), .DW(32), .LGFIFO(2), .TIMEOUT(8)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_scyc(i_scyc), .i_sstb(i_sstb), .i_swe(i_swe),
    .i_saddr(i_saddr), .i_sdata(i_sdata), .i_ssel(i_ssel),
    .o_sstall(o_sstall), .o_sack(o_sack), .o_serr(o_serr), .o_sdata(o_sdata),
    .o_mcyc(o_mcyc), .o_mstb(o_mstb), .o_mwe(o_mwe),
    .o_maddr(o_maddr), .o_mdata(o_mdata), .o_msel(o_msel),
    .i_mack(i_mack), .i_merr(i_merr), .i_mdata(i_mdata),
    .o_mcti(o_mcti), .o_mbte(o_mbte)
  );

  // Slave behaviour, set by the main sequence
  int          test_id       = 0;
  int          slv_delay     = 0;
  int          slv_err_txn   = -1;
  logic        slv_mute      = 1'b0;
  logic        slv_force_ack = 1'b0;
  logic [31:0] slv_rdata     = 32'h0;

  // Per-test observations, owned by the slave process
  int          cyc = 0;
  int          t_launch, t_resp, t_acks, t_errs, gap_cnt, slv_wait;
  int          first_launch_cyc, serr_cyc, last_ack_cyc;
  logic        mcyc_at_serr;
  logic [11:0] la_addr [0:15];
  logic [31:0] la_data [0:15];
  logic [3:0]  la_sel  [0:15];
  logic        la_we   [0:15];
  logic [31:0] ack_data [0:15];

  // Scripted classic slave plus upstream response monitor, acting 2 time units after each edge.
  initial begin
    int   seen_id;
    logic prev_stb;
    seen_id  = -1;
    prev_stb = 1'b0;
    i_mack   = 1'b0;
    i_merr   = 1'b0;
    i_mdata  = 32'h0;
    forever begin
      @(posedge i_clk);
      #2;
      cyc++;
      if (test_id != seen_id) begin
        seen_id = test_id;
        t_launch = 0; t_resp = 0; t_acks = 0; t_errs = 0; gap_cnt = 0; slv_wait = 0;
        first_launch_cyc = 0; serr_cyc = 0; last_ack_cyc = 0; mcyc_at_serr = 1'b0;
      end
      i_mack = 1'b0;
      i_merr = 1'b0;
      if (o_sack) begin
        if (t_acks < 16) ack_data[t_acks] = o_sdata;
        t_acks++;
        last_ack_cyc = cyc;
      end
      if (o_serr) begin
        t_errs++;
        serr_cyc = cyc;
        mcyc_at_serr = o_mcyc;
      end
      if (o_mcyc && !o_mstb) gap_cnt++;
      if (o_mcyc && o_mstb) begin
        if (!prev_stb) begin
          slv_wait = 0;
          if (t_launch == 0) first_launch_cyc = cyc;
          if (t_launch < 16) begin
            la_addr[t_launch] = o_maddr;
            la_data[t_launch] = o_mdata;
            la_sel[t_launch]  = o_msel;
            la_we[t_launch]   = o_mwe;
          end
          t_launch++;
        end
        if (!slv_mute && slv_wait == slv_delay) begin
          if (t_resp == slv_err_txn) begin
            i_merr = 1'b1;
          end else begin
            i_mack  = 1'b1;
            i_mdata = slv_rdata + 32'(t_resp);
          end
          t_resp++;
        end
        slv_wait++;
      end
      if (slv_force_ack) i_mack = 1'b1;
      prev_stb = o_mcyc && o_mstb;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Issue n back-to-back requests honouring o_sstall; stall4 is o_sstall right after the 4th accept.
  task automatic push_n(input int n, input logic we, input logic [11:0] base, output logic stall4);
    int   i;
    int   guard;
    logic acc;
    i = 0;
    guard = 0;
    stall4 = 1'b0;
    i_scyc = 1'b1;
    while (i < n && guard < 200) begin
      i_sstb  = 1'b1;
      i_swe   = we;
      i_saddr = base + 12'(i);
      i_sdata = 32'h1000_0000 + 32'(i);
      i_ssel  = 4'(i + 1);
      acc = !o_sstall;
      tick();
      guard++;
      if (acc) begin
        i++;
        if (i == 4) stall4 = o_sstall;
      end
    end
    i_sstb = 1'b0;
    check("push_done", 32'(i), 32'(n));
  endtask

  task automatic wait_acks(input int n);
    int g;
    g = 0;
    while (t_acks < n && g < 200) begin
      tick();
      g++;
    end
    check("ack_wait", 32'(t_acks), 32'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic s4;
    i_reset = 1'b1;
    i_scyc = 1'b0; i_sstb = 1'b0; i_swe = 1'b0;
    i_saddr = 12'h0; i_sdata = 32'h0; i_ssel = 4'h0;
    tick();
    tick();
    check("rst_mcyc", 32'(o_mcyc), 32'd0);
    check("rst_mstb", 32'(o_mstb), 32'd0);
    check("rst_sack", 32'(o_sack), 32'd0);
    check("rst_serr", 32'(o_serr), 32'd0);
    check("rst_sstall", 32'(o_sstall), 32'd0);
    check("const_cti", 32'(o_mcti), 32'd0);
    check("const_bte", 32'(o_mbte), 32'd0);
    i_reset = 1'b0;
    tick();

    // Single read: accept cycle 0, o_mstb cycle 2, ack cycle 3
    test_id = 1; slv_delay = 0; slv_err_txn = -1; slv_rdata = 32'hDEAD_BEEF;
    push_n(1, 1'b0, 12'h010, s4);
    check("rd_mstb_c1", 32'(o_mstb), 32'd0);
    tick();
    check("rd_mstb_c2", 32'(o_mstb), 32'd1);
    check("rd_mcyc_c2", 32'(o_mcyc), 32'd1);
    check("rd_maddr", 32'(o_maddr), 32'h010);
    check("rd_mwe", 32'(o_mwe), 32'd0);
    tick();
    check("rd_sack_c3", 32'(o_sack), 32'd1);
    check("rd_sdata_c3", o_sdata, 32'hDEAD_BEEF);
    check("rd_mstb_c3", 32'(o_mstb), 32'd0);
    check("rd_gap_mcyc", 32'(o_mcyc), 32'd1);
    tick();
    check("rd_idle_mcyc", 32'(o_mcyc), 32'd0);
    check("rd_sack_c4", 32'(o_sack), 32'd0);
    i_scyc = 1'b0;
    tick();

    // Burst of 6 writes, slave waits 3 cycles before each ack
    test_id = 2; slv_delay = 3; slv_rdata = 32'hCAFE_0000;
    push_n(6, 1'b1, 12'h100, s4);
    check("burst_stall4", 32'(s4), 32'd1);
    wait_acks(6);
    check("burst_launches", 32'(t_launch), 32'd6);
    check("burst_gaps", 32'(gap_cnt), 32'd6);
    check("burst_span", 32'(last_ack_cyc - first_launch_cyc), 32'd29);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("burst_ack%0d", k), ack_data[k], 32'hCAFE_0000 + 32'(k));
      check($sformatf("burst_addr%0d", k), 32'(la_addr[k]), 32'h100 + 32'(k));
      check($sformatf("burst_data%0d", k), la_data[k], 32'h1000_0000 + 32'(k));
      check($sformatf("burst_sel%0d", k), 32'(la_sel[k]), 32'(k + 1));
      check($sformatf("burst_we%0d", k), 32'(la_we[k]), 32'd1);
    end
    i_scyc = 1'b0;
    tick();

    // Three queued reads, the second one errors
    test_id = 3; slv_delay = 0; slv_err_txn = 1; slv_rdata = 32'h5555_0000;
    push_n(3, 1'b0, 12'h200, s4);
    repeat (4) tick();
    check("err_acks", 32'(t_acks), 32'd1);
    check("err_errs", 32'(t_errs), 32'd1);
    check("err_launches", 32'(t_launch), 32'd2);
    check("err_addr2", 32'(la_addr[1]), 32'h201);
    check("err_ackdata", ack_data[0], 32'h5555_0000);
    check("err_sdata_hold", o_sdata, 32'h5555_0000);
    check("err_drain_stall", 32'(o_sstall), 32'd1);
    check("err_drain_mcyc", 32'(o_mcyc), 32'd0);
    i_scyc = 1'b0;
    tick();
    check("err_exit_stall", 32'(o_sstall), 32'd0);
    slv_err_txn = -1;

    // Silent slave: timeout of 8 ends the cycle with an error
    test_id = 4; slv_mute = 1'b1;
    push_n(1, 1'b0, 12'h020, s4);
    repeat (14) tick();
    check("tmo_errs", 32'(t_errs), 32'd1);
    check("tmo_delay", 32'(serr_cyc - first_launch_cyc), 32'd9);
    check("tmo_mcyc_at_err", 32'(mcyc_at_serr), 32'd0);
    check("tmo_drain_stall", 32'(o_sstall), 32'd1);
    i_scyc = 1'b0;
    tick();

    // Abort: i_scyc drops while ACTIVE with two queued, ack arrives in the same cycle
    test_id = 5; slv_mute = 1'b1;
    push_n(3, 1'b0, 12'h300, s4);
    check("abt_pre_mstb", 32'(o_mstb), 32'd1);
    i_scyc = 1'b0;
    slv_force_ack = 1'b1;
    tick();
    check("abt_sack", 32'(o_sack), 32'd0);
    check("abt_mcyc", 32'(o_mcyc), 32'd0);
    check("abt_mstb", 32'(o_mstb), 32'd0);
    check("abt_stall", 32'(o_sstall), 32'd0);
    i_scyc = 1'b1;
    repeat (4) tick();
    check("abt_no_acks", 32'(t_acks), 32'd0);
    check("abt_launches", 32'(t_launch), 32'd1);
    check("abt_idle_mstb", 32'(o_mstb), 32'd0);
    slv_force_ack = 1'b0;
    i_scyc = 1'b0;
    tick();

    // Reset while ACTIVE with a full FIFO, then a fresh request
    test_id = 6; slv_mute = 1'b1;
    push_n(4, 1'b1, 12'h3F0, s4);
    check("rsta_full_stall", 32'(o_sstall), 32'd1);
    check("rsta_active", 32'(o_mstb), 32'd1);
    i_reset = 1'b1;
    tick();
    check("rsta_mcyc", 32'(o_mcyc), 32'd0);
    check("rsta_mstb", 32'(o_mstb), 32'd0);
    check("rsta_sack", 32'(o_sack), 32'd0);
    check("rsta_serr", 32'(o_serr), 32'd0);
    check("rsta_stall", 32'(o_sstall), 32'd0);
    i_reset = 1'b0;
    i_scyc = 1'b0;
    tick();
    check("rsta_no_resp", 32'(t_acks + t_errs), 32'd0);

    test_id = 7; slv_mute = 1'b0; slv_delay = 1; slv_rdata = 32'h1234_5678;
    push_n(1, 1'b0, 12'h0AB, s4);
    wait_acks(1);
    check("post_sdata", o_sdata, 32'h1234_5678);
    check("post_addr", 32'(la_addr[0]), 32'h0AB);
    check("post_errs", 32'(t_errs), 32'd0);
    i_scyc = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
